// File: rtl/aes_block_loader.sv
// Board-side loader: assembles plaintext/key from debounced switch chunks and runs the AES core.
// Build option AES_LOADER_KAT_EN resets into READY with the FIPS-197 known-answer vectors loaded.
module aes_block_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic         clk,
    input  logic         btnC,
    input  logic [15:0]  sw,
    input  logic         btn_load,
    input  logic         btn_go,
    input  logic         aes_done,
    input  logic [127:0] aes_ciphertext,
    output logic         aes_start,
    output logic [127:0] aes_plaintext,
    output logic [127:0] aes_key,
    output logic [127:0] result,
    output logic         result_valid,
    output logic         err_timeout,
    output logic [3:0]   chunk_idx,
    output logic [1:0]   state
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StReady = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

`ifdef AES_LOADER_KAT_EN
    localparam state_e       ResetState = StReady;
    localparam logic [127:0] PtReset    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KeyReset   = 128'h000102030405060708090a0b0c0d0e0f;
`else
    localparam state_e       ResetState = StLoad;
    localparam logic [127:0] PtReset    = '0;
    localparam logic [127:0] KeyReset   = '0;
`endif

    // Button conditioning: bit 0 = load, bit 1 = go
    logic [1:0]     btn_raw;
    logic [1:0]     sync1_q, sync2_q, level_q, level_dly_q, press_q;
    logic [DbW-1:0] db_cnt_q [2];

    assign btn_raw = {btn_go, btn_load};

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            press_q     <= '0;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            for (int b = 0; b < 2; b++) begin
                // Any agreement between input and accepted level restarts the stability count
                if (sync2_q[b] == level_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DbLast) begin
                    level_q[b]  <= sync2_q[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    logic load_press, go_press;
    assign load_press = press_q[0];
    assign go_press   = press_q[1];

    state_e         state_q, state_d;
    logic [ToW-1:0] tmo_cnt_q;
    logic           tmo_hit;
    logic           do_write, do_start, do_capture, do_timeout, do_reload;
    logic [127:0]   pt_q, key_q, result_q;
    logic [3:0]     chunk_idx_q;
    logic           start_q, valid_q, err_q;

    assign tmo_hit = (tmo_cnt_q == ToLast);

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) state_q <= ResetState;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:  if (load_press && chunk_idx_q == 4'd15) state_d = StReady;
            StReady: if (go_press) state_d = StRun;
            StRun:   if (aes_done || tmo_hit) state_d = StDone;
            StDone: begin
                if (go_press)        state_d = StRun;
                else if (load_press) state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        do_write   = (state_q == StLoad) && load_press;
        do_start   = (state_q == StReady || state_q == StDone) && go_press;
        do_capture = (state_q == StRun) && aes_done;
        // A done arriving together with the timeout takes priority
        do_timeout = (state_q == StRun) && !aes_done && tmo_hit;
        do_reload  = (state_q == StDone) && load_press && !go_press;
    end

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            pt_q        <= PtReset;
            key_q       <= KeyReset;
            chunk_idx_q <= '0;
            start_q     <= 1'b0;
            tmo_cnt_q   <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_q <= do_start;

            if (state_q == StRun) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else                  tmo_cnt_q <= '0;

            if (do_write) begin
                if (chunk_idx_q[3]) key_q[{chunk_idx_q[2:0], 4'b0000} +: 16] <= sw;
                else                pt_q[{chunk_idx_q[2:0], 4'b0000} +: 16]  <= sw;
                chunk_idx_q <= chunk_idx_q + 4'd1;
            end else if (do_reload) begin
                chunk_idx_q <= '0;
            end

            if (do_start || do_reload) begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (do_capture) begin
                result_q <= aes_ciphertext;
                valid_q  <= 1'b1;
            end else if (do_timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign aes_start     = start_q;
    assign aes_plaintext = pt_q;
    assign aes_key       = key_q;
    assign result        = result_q;
    assign result_valid  = valid_q;
    assign err_timeout   = err_q;
    assign chunk_idx     = chunk_idx_q;
    assign state         = state_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: vector table, directed corner cases and a
// randomized run against a chunk-level reference model; behavioural core answers 11 cycles after start.
module tb_aes_block_loader;

    localparam int unsigned D = 4;
    localparam int unsigned T = 16;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         btnC;
    logic [15:0]  sw;
    logic         btn_load, btn_go;
    logic         aes_done;
    logic [127:0] aes_ciphertext;
    logic         aes_start;
    logic [127:0] aes_plaintext, aes_key, result;
    logic         result_valid, err_timeout;
    logic [3:0]   chunk_idx;
    logic [1:0]   state;

    aes_block_loader #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .btnC          (btnC),
        .sw            (sw),
        .btn_load      (btn_load),
        .btn_go        (btn_go),
        .aes_done      (aes_done),
        .aes_ciphertext(aes_ciphertext),
        .aes_start     (aes_start),
        .aes_plaintext (aes_plaintext),
        .aes_key       (aes_key),
        .result        (result),
        .result_valid  (result_valid),
        .err_timeout   (err_timeout),
        .chunk_idx     (chunk_idx),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, start_count = 0, start_cyc = -1, tmo_cyc = -1;
    logic err_prev = 1'b0;
    logic core_hang = 1'b0, core_busy = 1'b0, inject_done = 1'b0;
    logic [127:0] inject_ct = '0;
    int core_rem = 0;

    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == KAT_PT && key == KAT_KEY) return KAT_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    // Behavioural AES core plus start/timeout monitor
    initial begin
        aes_done       = 1'b0;
        aes_ciphertext = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            aes_done = 1'b0;
            if (aes_start) begin
                start_count++;
                start_cyc = cyc;
            end
            if (err_timeout && !err_prev) tmo_cyc = cyc;
            err_prev = err_timeout;
            if (btnC) begin
                core_busy = 1'b0;
            end else if (core_busy) begin
                core_rem--;
                if (core_rem == 0) begin
                    core_busy      = 1'b0;
                    aes_done       = 1'b1;
                    aes_ciphertext = core_fn(aes_plaintext, aes_key);
                end
            end
            if (aes_start && !core_hang && !btnC) begin
                core_busy = 1'b1;
                core_rem  = 11;
            end
            if (inject_done) begin
                aes_done       = 1'b1;
                aes_ciphertext = inject_ct;
                inject_done    = 1'b0;
            end
        end
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic ld, input logic go, input logic [15:0] val, input int hold);
        sw       = val;
        btn_load = ld;
        btn_go   = go;
        tick(hold);
        btn_load = 1'b0;
        btn_go   = 1'b0;
        tick(D + 6);
    endtask

    task automatic check_reset(input string tag);
`ifdef AES_LOADER_KAT_EN
        check({tag, "_state"}, 128'(state), 128'd1);
        check({tag, "_pt"}, aes_plaintext, KAT_PT);
        check({tag, "_key"}, aes_key, KAT_KEY);
`else
        check({tag, "_state"}, 128'(state), 128'd0);
        check({tag, "_pt"}, aes_plaintext, '0);
        check({tag, "_key"}, aes_key, '0);
`endif
        check({tag, "_idx"}, 128'(chunk_idx), 128'd0);
        check({tag, "_start"}, 128'(aes_start), 128'd0);
        check({tag, "_result"}, result, '0);
        check({tag, "_valid"}, 128'(result_valid), 128'd0);
        check({tag, "_err"}, 128'(err_timeout), 128'd0);
    endtask

    typedef struct {
        logic        ld;
        logic        go;
        logic [15:0] sw;
        logic [1:0]  exp_state;
        logic [3:0]  exp_idx;
        int          exp_starts;
    } vec_t;

    vec_t         tbl[$];
    logic [15:0]  m_chunk[16];
    logic [255:0] kat_all;

    function automatic logic [127:0] m_word(input int base);
        logic [127:0] w = '0;
        for (int i = 0; i < 8; i++) w[16*i +: 16] = m_chunk[base + i];
        return w;
    endfunction

    initial begin
        int base_starts, seen, r;
        logic [15:0] val;
        logic ld, go;
        int m_state, m_idx, m_starts;
        logic [127:0] m_res;
        logic m_valid, m_err;

        btnC = 1'b1;
        sw = '0;
        btn_load = 1'b0;
        btn_go = 1'b0;
        tick(3);
        check_reset("reset");
        btnC = 1'b0;
        tick(2);

`ifdef AES_LOADER_KAT_EN
        press(1'b0, 1'b1, 16'h0, D + 6);
        tick(20);
        check("kat_boot_result", result, KAT_CT);
        check("kat_boot_valid", 128'(result_valid), 128'd1);
        press(1'b1, 1'b0, 16'h0, D + 6);
        check("kat_boot_reload", 128'(state), 128'd0);
`endif

        // Vector table: FIPS-197 entry with an ignored go in LOAD and an ignored load in READY
        kat_all = {KAT_KEY, KAT_PT};
        for (int k = 0; k < 16; k++) begin
            tbl.push_back('{1'b1, 1'b0, kat_all[16*k +: 16], (k == 15) ? 2'd1 : 2'd0,
                            4'((k + 1) % 16), 0});
            if (k == 4) tbl.push_back('{1'b0, 1'b1, 16'hdead, 2'd0, 4'd5, 0});
        end
        tbl.push_back('{1'b1, 1'b0, 16'hbeef, 2'd1, 4'd0, 0});
        tbl.push_back('{1'b0, 1'b1, 16'h0000, 2'd3, 4'd0, 1});

        base_starts = start_count;
        foreach (tbl[i]) begin
            press(tbl[i].ld, tbl[i].go, tbl[i].sw, D + 6);
            if (tbl[i].go) tick(20);
            check($sformatf("tbl%0d_state", i), 128'(state), 128'(tbl[i].exp_state));
            check($sformatf("tbl%0d_idx", i), 128'(chunk_idx), 128'(tbl[i].exp_idx));
            check($sformatf("tbl%0d_starts", i), 128'(start_count - base_starts),
                  128'(tbl[i].exp_starts));
        end
        check("kat_pt", aes_plaintext, KAT_PT);
        check("kat_key", aes_key, KAT_KEY);
        check("kat_result", result, KAT_CT);
        check("kat_valid", 128'(result_valid), 128'd1);
        check("kat_err", 128'(err_timeout), 128'd0);

        // Timeout: core never answers
        core_hang = 1'b1;
        tmo_cyc = -1;
        press(1'b0, 1'b1, 16'h0, D + 6);
        tick(25);
        check("tmo_latency", 128'(tmo_cyc - start_cyc), 128'd16);
        check("tmo_err", 128'(err_timeout), 128'd1);
        check("tmo_valid", 128'(result_valid), 128'd0);
        check("tmo_state", 128'(state), 128'd3);
        check("tmo_result_kept", result, KAT_CT);
        core_hang = 1'b0;
        press(1'b1, 1'b0, 16'h0, D + 6);
        check("reload_state", 128'(state), 128'd0);
        check("reload_idx", 128'(chunk_idx), 128'd0);
        check("reload_err", 128'(err_timeout), 128'd0);

        // Debounce: short glitches never register, clean and long presses write once each
        repeat (3) begin
            btn_load = 1'b1;
            tick(3);
            btn_load = 1'b0;
            tick(3);
        end
        tick(D + 6);
        check("glitch_idx", 128'(chunk_idx), 128'd0);
        press(1'b1, 1'b0, 16'h1234, 6);
        check("clean_idx", 128'(chunk_idx), 128'd1);
        check("clean_data", 128'(aes_plaintext[15:0]), 128'h1234);
        press(1'b1, 1'b0, 16'h5678, 50);
        check("hold_idx", 128'(chunk_idx), 128'd2);
        check("hold_data", 128'(aes_plaintext[31:16]), 128'h5678);

        // Stray done in LOAD
        inject_ct = {$urandom, $urandom, $urandom, $urandom};
        inject_done = 1'b1;
        tick(4);
        check("stray_result", result, KAT_CT);
        check("stray_valid", 128'(result_valid), 128'd0);
        check("stray_state", 128'(state), 128'd0);

        // Reset three cycles into a run
        for (int k = 2; k < 16; k++) press(1'b1, 1'b0, 16'($urandom), D + 6);
        btn_go = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (aes_start) seen = 1;
        end
        check("run_start_seen", 128'(seen), 128'd1);
        btn_go = 1'b0;
        tick(3);
        btnC = 1'b1;
        #1;
        check_reset("midrun");
        base_starts = start_count;
        tick(3);
        btnC = 1'b0;
        tick(20);
        check("midrun_no_start", 128'(start_count - base_starts), 128'd0);

`ifdef AES_LOADER_KAT_EN
        press(1'b0, 1'b1, 16'h0, D + 6);
        tick(20);
        check("midrun_kat_result", result, KAT_CT);
        press(1'b1, 1'b0, 16'h0, D + 6);
        for (int i = 0; i < 16; i++) m_chunk[i] = kat_all[16*i +: 16];
        m_res = KAT_CT;
`else
        for (int i = 0; i < 16; i++) m_chunk[i] = '0;
        m_res = '0;
`endif
        m_state = 0;
        m_idx = 0;
        m_valid = 1'b0;
        m_err = 1'b0;
        m_starts = start_count;

        // Randomized operations against the reference model
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 8));
            if (r == 8) begin
                inject_ct = {$urandom, $urandom, $urandom, $urandom};
                inject_done = 1'b1;
                tick(4);
            end else begin
                ld = (r <= 5) || (r == 7);
                go = (r == 6) || (r == 7);
                val = 16'($urandom);
                press(ld, go, val, D + 6);
                if (go) tick(20);
                if (m_state == 0) begin
                    if (ld) begin
                        m_chunk[m_idx] = val;
                        m_idx = (m_idx + 1) % 16;
                        if (m_idx == 0) m_state = 1;
                    end
                end else if (go) begin
                    m_starts++;
                    m_res = core_fn(m_word(0), m_word(8));
                    m_valid = 1'b1;
                    m_err = 1'b0;
                    m_state = 3;
                end else if (ld && m_state == 3) begin
                    m_valid = 1'b0;
                    m_err = 1'b0;
                    m_idx = 0;
                    m_state = 0;
                end
            end
            check($sformatf("rnd%0d_state", n), 128'(state), 128'(m_state));
            check($sformatf("rnd%0d_idx", n), 128'(chunk_idx), 128'(m_idx));
            check($sformatf("rnd%0d_pt", n), aes_plaintext, m_word(0));
            check($sformatf("rnd%0d_key", n), aes_key, m_word(8));
            check($sformatf("rnd%0d_result", n), result, m_res);
            check($sformatf("rnd%0d_valid", n), 128'(result_valid), 128'(m_valid));
            check($sformatf("rnd%0d_err", n), 128'(err_timeout), 128'(m_err));
            check($sformatf("rnd%0d_starts", n), 128'(start_count), 128'(m_starts));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Input-side counterpart to the board-level AES ciphertext display path: assembles a 128-bit plaintext and 128-bit key from 16-bit switch chunks entered by pushbutton.
- Starts the sequential AES core with a start/done handshake and captures the ciphertext for the LED/7-seg display logic.
- Sits between Basys3 board I/O (sw, buttons) and the AES core.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, stable-level cycles required to accept a button change (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 1024, maximum cycles in RUN waiting for aes_done before flagging an error.

Ports:
- clk  input  1  100 MHz system clock; single clock domain.
- btnC  input  1  reset, asynchronous, active-high.
- sw  input  16  data chunk to write.
- btn_load  input  1  raw pushbutton; writes the next chunk.
- btn_go  input  1  raw pushbutton; starts encryption.
- aes_done  input  1  one-cycle pulse from the core; ciphertext is valid in that cycle.
- aes_ciphertext  input  128  core result.
- aes_start  output  1  one-cycle start pulse to the core.
- aes_plaintext  output  128  plaintext register; held stable from start until done.
- aes_key  output  128  key register; held stable from start until done.
- result  output  128  captured ciphertext.
- result_valid  output  1  result holds a fresh ciphertext.
- err_timeout  output  1  last run timed out.
- chunk_idx  output  4  next chunk to be written.
- state  output  2  LOAD=0, READY=1, RUN=2, DONE=3.

Behaviour:
- Reset values: all outputs 0, state=LOAD, chunk_idx=0. Reset mid-RUN aborts immediately, with no aes_start glitch.
- Button conditioning: each button uses a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. The counter clears on any mismatch break.
  - A debounced rising edge produces a 1-cycle press pulse. Latency from stable raw press to pulse is DEBOUNCE_CYCLES+3 cycles.
- Chunk map: chunk k (0..7) writes aes_plaintext[16k+15:16k]. Chunk k (8..15) writes aes_key[16(k-8)+15:16(k-8)]. Chunk 0 is the least significant plaintext halfword.
- State LOAD:
  - Load press writes sw to chunk_idx and increments chunk_idx.
  - Writing chunk 15 wraps chunk_idx to 0 and moves to READY.
  - Go press is ignored.
- State READY:
  - Go press asserts aes_start for exactly 1 cycle (the cycle after the press pulse), clears result_valid and err_timeout, and moves to RUN.
  - Load press is ignored.
- State RUN:
  - Timeout counter starts at 0 and increments each cycle.
  - aes_done: result<=aes_ciphertext, result_valid<=1, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES first: err_timeout<=1, result unchanged, result_valid stays 0, go to DONE.
  - Button presses are ignored. An aes_done arriving in the same cycle as the timeout wins.
- State DONE:
  - Go press reruns with the same plaintext/key (same actions as from READY).
  - Load press clears result_valid and err_timeout, sets chunk_idx=0 and returns to LOAD. That press writes nothing.
- Simultaneous load and go press pulses in one cycle: go wins in READY/DONE; load wins in LOAD.
- aes_done outside RUN is ignored.
- aes_start is never asserted outside the READY/DONE-to-RUN transition.

Optional Feature:
- Macro: AES_LOADER_KAT_EN.
- Defined: reset loads aes_plaintext=128'h00112233445566778899aabbccddeeff and aes_key=128'h000102030405060708090a0b0c0d0e0f, with state=READY and chunk_idx=0, so a single go press runs the FIPS-197 known-answer test.
- Undefined: both registers reset to 0 and state=LOAD.

Test Plan:
- Test configuration: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16, behavioural core that pulses done 11 cycles after start.
- Entry and KAT run: 16 load presses with sw carrying FIPS-197 halfwords (chunk 0=16'heeff ... chunk 15=16'h0001), then go -> state READY after the 16th press; aes_plaintext/aes_key match the KAT values; 1 aes_start pulse; result=128'h69c4e0d86a7b0430d8cdb78070b4c55a; result_valid=1; state=DONE.
- Debounce: 3-cycle glitches on btn_load, then a 6-cycle clean press -> chunk_idx advances by exactly 1; a press held for 50 cycles gives one write.
- Timeout: core model never asserts done -> err_timeout=1 exactly 16 cycles after aes_start; result_valid=0; state=DONE. A following load press -> state LOAD, chunk_idx=0, err_timeout=0.
- Ignore rules: go press in LOAD at chunk_idx=5 -> no aes_start. Load press in READY -> registers unchanged. aes_done pulse in LOAD -> result unchanged.
- Reset mid-RUN: assert btnC 3 cycles after aes_start -> all outputs 0 and state LOAD immediately. With AES_LOADER_KAT_EN defined: state READY, KAT registers loaded, and one go press yields the KAT ciphertext above.
